load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage sitting directly upstream of data_memory in the multicycle datapath.
- Accepts one load/store request from execute, computes the effective address, checks alignment and range, and drives MemR/MemW/address/writeData to data_memory with defined timing.
- Captures readData into the LMD register and reports completion or fault back to the control FSM.

Parameters:
- ADDR_W, 10, word-index width of data memory (1024 words)
- DATA_W, 32, data word width
- OFFS_W, 16, immediate offset width (sign-extended)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_op  in  2  00 none, 01 LW, 10 SW, 11 reserved
- req_opcode  in  6  instruction opcode, forwarded to memory
- base  in  32  base register value
- offset  in  OFFS_W  signed byte offset
- store_data  in  32  SW data
- mem_opcode  out  6  to data_memory opcode
- mem_addr  out  32  to data_memory address: {22'b0, word index}
- mem_wdata  out  32  to data_memory writeData
- MemR  out  1  read strobe
- MemW  out  1  write strobe
- mem_rdata  in  32  from data_memory readData
- lmd  out  32  load memory data register
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle pulse with done on misaligned, out-of-range or illegal op
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, asynchronous): state IDLE, req_ready=1, MemR=MemW=0, done=fault=busy=0, lmd=0, mem_addr=mem_wdata=0, mem_opcode=0. Reset mid-operation aborts immediately. No strobe survives reset and no done is produced for the aborted request.
- States: IDLE, AGEN, ACCESS, CAPTURE, RESP.
- IDLE: on req_valid&req_ready, latch req_op, req_opcode, base, offset and store_data, then go to AGEN. req_valid while busy is ignored and the request is not queued.
- AGEN (cycle 1):
  - ea = base + sign_extend(offset), computed mod 2^32.
  - Fault if ea[1:0]!=0, ea[31:ADDR_W+2]!=0, or req_op is 00 or 11.
  - On fault, go to RESP with fault flagged. No strobe is ever asserted.
  - Otherwise register mem_addr = {0, ea[ADDR_W+1:2]}, mem_wdata and mem_opcode, then go to ACCESS.
- ACCESS (cycle 2):
  - SW: MemW=1 for exactly this cycle, then RESP.
  - LW: MemR=1, then CAPTURE.
- CAPTURE (cycle 3, LW only): MemR stays 1. At the end of the cycle, lmd <= mem_rdata. Then RESP.
- RESP: done=1 for one cycle, with fault=1 if faulted. Then IDLE.
- Latency from accept edge to done: SW 3 cycles, LW 4 cycles, fault 2 cycles.
- Steady-state throughput: SW one per 4 cycles, LW one per 5 cycles.
- MemR and MemW are never high together and never high outside ACCESS/CAPTURE.
- mem_addr, mem_wdata and mem_opcode hold stable from AGEN exit until the next accepted request.
- lmd holds its value until the next successful LW. SW and faults leave it unchanged.
- Boundaries:
  - ea=0x0 and ea=0xFFC are legal (word 0 and word 1023).
  - ea=0x1000 faults.
  - Negative offset wrapping below 0 yields a large ea, which faults.

Decomposition:
- Package lsu_pkg: req_op encodings (OP_NONE, OP_LW, OP_SW, OP_RSV), state enum, MEM_WORDS=1024, DATA_W, ADDR_W.
- Sub-module lsu_agen (combinational): inputs base and offset; outputs ea, word_idx, misaligned and out_of_range. Instantiated once.

Test Plan:
- SW: base=0x100, offset=0x8, store_data=0xDEADBEEF. Required: MemW high only in cycle 2 with mem_addr=0x42 and mem_wdata=0xDEADBEEF; done in cycle 3; fault=0.
- LW after that SW: base=0x108, offset=0. Required: MemR high in cycles 2-3 with mem_addr=0x42; lmd=0xDEADBEEF; done in cycle 4.
- Misaligned: base=0x100, offset=0x2. Required: fault=done=1 in cycle 2; MemR and MemW never asserted; lmd unchanged.
- Range: base=0x10, offset=-0x14 (ea=0xFFFFFFFC) faults. base=0xFFC, offset=0 loads word 1023 without fault. base=0x1000 faults.
- rst low asserted during ACCESS of an SW. Required: MemW drops immediately; no done; req_ready=1 after release; a subsequent LW completes normally.
- req_valid held high for 10 cycles with alternating SW/LW. Required: each request is accepted only when req_ready=1; one done per accepted request; never two strobes at once.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and sizes for the load/store unit
//
// Purpose: request-op encodings, FSM state enum and memory geometry used by
// load_store_unit and lsu_agen. No ports.

package lsu_pkg;

  localparam int ADDR_W    = 10;            // word-index width of data memory
  localparam int DATA_W    = 32;            // data word width
  localparam int OFFS_W    = 16;            // immediate offset width
  localparam int MEM_WORDS = 1 << ADDR_W;   // 1024 words

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_LW   = 2'b01,
    OP_SW   = 2'b10,
    OP_RSV  = 2'b11
  } req_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AGEN    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  // Only LW and SW reach memory; NONE and RSV complete with a fault.
  function automatic logic op_is_legal(req_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsu_agen.sv
// rtl/lsu_agen.sv - effective-address generation and address checks
//
// Purpose: ea = base + sign_extend(offset) mod 2^32, plus word index and the
// alignment / range flags used by the load/store FSM. Purely combinational.
// Ports:
//   base         in   32       base register value
//   offset       in   OFFS_W   signed byte offset
//   ea           out  32       effective byte address
//   word_idx     out  ADDR_W   word index ea[ADDR_W+1:2]
//   misaligned   out  1        ea[1:0] != 0
//   out_of_range out  1        ea above the last memory word

module lsu_agen #(
  parameter int ADDR_W = 10,
  parameter int OFFS_W = 16
) (
  input  logic [31:0]       base,
  input  logic [OFFS_W-1:0] offset,
  output logic [31:0]       ea,
  output logic [ADDR_W-1:0] word_idx,
  output logic              misaligned,
  output logic              out_of_range
);

  // Wraps mod 2^32, so a negative offset below zero lands at a huge address
  // and is rejected by the range check rather than aliasing low memory.
  assign ea           = base + {{(32-OFFS_W){offset[OFFS_W-1]}}, offset};
  assign word_idx     = ea[ADDR_W+1:2];
  assign misaligned   = |ea[1:0];
  assign out_of_range = |ea[31:ADDR_W+2];

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multicycle load/store stage in front of data_memory
//
// Purpose: accepts one LW/SW request, generates and checks the effective
// address, drives MemR/MemW with fixed timing, captures read data into LMD
// and reports done (with fault) back to the control FSM.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_op, req_opcode       operation (00 none, 01 LW, 10 SW, 11 rsv), opcode
//   base, offset, store_data request operands
//   mem_opcode, mem_addr     to data_memory (mem_addr = {0, word index})
//   mem_wdata, MemR, MemW    to data_memory
//   mem_rdata                from data_memory
//   lmd                      load memory data register
//   done, fault, busy        completion pulse, fault pulse, not-IDLE

module load_store_unit #(
  parameter int ADDR_W = $clog2(lsu_pkg::MEM_WORDS),
  parameter int DATA_W = lsu_pkg::DATA_W,
  parameter int OFFS_W = lsu_pkg::OFFS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [5:0]        req_opcode,
  input  logic [31:0]       base,
  input  logic [OFFS_W-1:0] offset,
  input  logic [DATA_W-1:0] store_data,
  output logic [5:0]        mem_opcode,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              MemR,
  output logic              MemW,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] lmd,
  output logic              done,
  output logic              fault,
  output logic              busy
);

  import lsu_pkg::*;

  lsu_state_e        state_q;
  req_op_e           op_q;
  logic [5:0]        opcode_q;
  logic [31:0]       base_q;
  logic [OFFS_W-1:0] offset_q;
  logic [DATA_W-1:0] sdata_q;

  logic [5:0]        mem_opcode_q;
  logic [31:0]       mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              memr_q;
  logic              memw_q;
  logic [DATA_W-1:0] lmd_q;
  logic              done_q;
  logic              fault_q;
  logic              ready_q;
  logic              busy_q;

  logic [31:0]       ea;
  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              agen_fault;
  logic              unused_ea;

  lsu_agen #(
    .ADDR_W (ADDR_W),
    .OFFS_W (OFFS_W)
  ) u_agen (
    .base         (base_q),
    .offset       (offset_q),
    .ea           (ea),
    .word_idx     (word_idx),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  // The full byte address is only consumed through word_idx and the flags.
  assign unused_ea  = ^ea;
  assign agen_fault = misaligned | out_of_range | ~op_is_legal(op_q);

  // All outputs are registered; each state transition sets up the strobes
  // and pulses that must be visible during the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_NONE;
      opcode_q     <= '0;
      base_q       <= '0;
      offset_q     <= '0;
      sdata_q      <= '0;
      mem_opcode_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      memr_q       <= 1'b0;
      memw_q       <= 1'b0;
      lmd_q        <= '0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            op_q     <= req_op_e'(req_op);
            opcode_q <= req_opcode;
            base_q   <= base;
            offset_q <= offset;
            sdata_q  <= store_data;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_AGEN;
          end
        end

        ST_AGEN: begin
          if (agen_fault) begin
            // Memory-facing registers keep the previous request's values.
            done_q  <= 1'b1;
            fault_q <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            mem_addr_q   <= {{(32-ADDR_W){1'b0}}, word_idx};
            mem_wdata_q  <= sdata_q;
            mem_opcode_q <= opcode_q;
            if (op_q == OP_SW) begin
              memw_q <= 1'b1;
            end else begin
              memr_q <= 1'b1;
            end
            state_q <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (op_q == OP_SW) begin
            memw_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            // MemR stays high through CAPTURE so readData is settled.
            state_q <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          memr_q  <= 1'b0;
          lmd_q   <= mem_rdata;
          done_q  <= 1'b1;
          state_q <= ST_RESP;
        end

        ST_RESP: begin
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          memr_q  <= 1'b0;
          memw_q  <= 1'b0;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign mem_opcode = mem_opcode_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign MemR       = memr_q;
  assign MemW       = memw_q;
  assign lmd        = lmd_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [5:0]  req_opcode = 6'd0;
  logic [31:0] base = 32'd0;
  logic [15:0] offset = 16'd0;
  logic [31:0] store_data = 32'd0;
  logic [5:0]  mem_opcode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        MemR;
  logic        MemW;
  logic [31:0] mem_rdata;
  logic [31:0] lmd;
  logic        done;
  logic        fault;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_opcode (req_opcode),
    .base       (base),
    .offset     (offset),
    .store_data (store_data),
    .mem_opcode (mem_opcode),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .MemR       (MemR),
    .MemW       (MemW),
    .mem_rdata  (mem_rdata),
    .lmd        (lmd),
    .done       (done),
    .fault      (fault),
    .busy       (busy)
  );

  function automatic logic [31:0] pat(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  // data_memory stand-in: asynchronous read, write on rising edge with MemW
  logic [31:0] dmem [0:1023];
  logic        init_mem = 1'b1;
  assign mem_rdata = dmem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= pat(i);
    end else if (MemW) begin
      dmem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  // Reference model state
  logic [31:0] model_mem [0:1023];
  logic [31:0] model_lmd    = 32'd0;
  logic [31:0] model_addr   = 32'd0;
  logic [31:0] model_wdata  = 32'd0;
  logic [5:0]  model_opcode = 6'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Read and write strobes must never overlap.
  always @(negedge clk) begin
    if (rst && !init_mem) check_eq("strobe_excl", {31'd0, MemR & MemW}, 32'd0);
  end

  // Model one request from its operands; returns fault and expected latency.
  task automatic model_req(input logic [1:0] op, input logic [5:0] opc, input logic [31:0] b,
                           input logic [15:0] off, input logic [31:0] sd,
                           output logic flt, output int lat, output logic [7:0] er, output logic [7:0] ew);
    logic [31:0] ea;
    int w;
    ea  = b + {{16{off[15]}}, off};
    flt = (ea % 4 != 0) || (ea >= 32'h1000) || (op == 2'b00) || (op == 2'b11);
    w   = int'(ea / 4) % 1024;
    er  = 8'd0;
    ew  = 8'd0;
    if (flt) begin
      lat = 2;
    end else begin
      model_addr   = ea / 4;
      model_wdata  = sd;
      model_opcode = opc;
      if (op == 2'b10) begin
        lat = 3;
        ew  = 8'b0000_0100;
        model_mem[w] = sd;
      end else begin
        lat = 4;
        er  = 8'b0000_1100;
        model_lmd = model_mem[w];
      end
    end
  endtask

  task automatic run_req(input string name, input logic [1:0] op, input logic [5:0] opc,
                         input logic [31:0] b, input logic [15:0] off, input logic [31:0] sd);
    logic       flt;
    int         lat;
    logic [7:0] er, ew, gr, gw;
    int         done_k, done_n;
    logic       fault_seen;
    model_req(op, opc, b, off, sd, flt, lat, er, ew);
    gr = 8'd0; gw = 8'd0; done_k = 0; done_n = 0; fault_seen = 1'b0;
    @(negedge clk);
    check_eq({name, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_op = op; req_opcode = opc; base = b; offset = off; store_data = sd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      gr[k] = MemR;
      gw[k] = MemW;
      if (done) begin
        done_n++;
        if (done_k == 0) begin
          done_k = k;
          fault_seen = fault;
        end
      end
      if (k < 7) @(negedge clk);
    end
    check_eq({name, ".done_cycle"}, done_k, lat);
    check_eq({name, ".done_count"}, done_n, 1);
    check_eq({name, ".fault"}, {31'd0, fault_seen}, {31'd0, flt});
    check_eq({name, ".memr_cycles"}, {24'd0, gr}, {24'd0, er});
    check_eq({name, ".memw_cycles"}, {24'd0, gw}, {24'd0, ew});
    check_eq({name, ".mem_addr"}, mem_addr, model_addr);
    check_eq({name, ".mem_wdata"}, mem_wdata, model_wdata);
    check_eq({name, ".mem_opcode"}, {26'd0, mem_opcode}, {26'd0, model_opcode});
    check_eq({name, ".lmd"}, lmd, model_lmd);
    check_eq({name, ".busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check_eq({name, ".ready"}, {31'd0, req_ready}, 32'd1);
    check_eq({name, ".busy"}, {31'd0, busy}, 32'd0);
    check_eq({name, ".strobes"}, {30'd0, MemR, MemW}, 32'd0);
    check_eq({name, ".done_fault"}, {30'd0, done, fault}, 32'd0);
    check_eq({name, ".lmd"}, lmd, model_lmd);
    check_eq({name, ".mem_addr"}, mem_addr, model_addr);
    check_eq({name, ".mem_wdata"}, mem_wdata, model_wdata);
    check_eq({name, ".mem_opcode"}, {26'd0, mem_opcode}, {26'd0, model_opcode});
  endtask

  initial begin
    int accepts, dones, faults, sd_w;
    logic pend;
    logic [1:0] r_op;
    logic [31:0] r_base;
    logic [15:0] r_off;
    logic        tf;
    int          tl;
    logic [7:0]  ter, tew;

    for (int i = 0; i < 1024; i++) model_mem[i] = pat(i);

    // Reset
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Directed
    run_req("sw_dir", 2'b10, 6'h2B, 32'h100, 16'h0008, 32'hDEADBEEF);
    run_req("lw_dir", 2'b01, 6'h23, 32'h108, 16'h0000, 32'h0);
    check_eq("lw_dir.value", lmd, 32'hDEADBEEF);
    run_req("misalign", 2'b01, 6'h23, 32'h100, 16'h0002, 32'h0);
    run_req("neg_wrap", 2'b01, 6'h23, 32'h10, 16'hFFEC, 32'h0);
    run_req("word0_sw", 2'b10, 6'h2B, 32'h0, 16'h0000, 32'h0BADF00D);
    run_req("word0_lw", 2'b01, 6'h23, 32'h0, 16'h0000, 32'h0);
    run_req("top_sw", 2'b10, 6'h2B, 32'hFF0, 16'h000C, 32'h13572468);
    run_req("top_lw", 2'b01, 6'h23, 32'hFFC, 16'h0000, 32'h0);
    run_req("past_top", 2'b01, 6'h23, 32'h1000, 16'h0000, 32'h0);
    run_req("op_none", 2'b00, 6'h00, 32'h40, 16'h0000, 32'h1);
    run_req("op_rsv", 2'b11, 6'h3F, 32'h40, 16'h0000, 32'h1);

    // Randomized
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       r_op = 2'b00;
        1:       r_op = 2'b11;
        2, 3, 4, 5: r_op = 2'b01;
        default: r_op = 2'b10;
      endcase
      if ($urandom_range(0, 4) == 0) r_base = $urandom;
      else r_base = $urandom_range(0, 32'h1010) & 32'hFFFF_FFFC;
      r_off = 16'(($urandom_range(0, 31) - 16) * 4);
      if ($urandom_range(0, 5) == 0) r_off = r_off + 16'($urandom_range(1, 3));
      run_req($sformatf("rnd%0d", n), r_op, 6'($urandom), r_base, r_off, $urandom);
    end

    // Back-to-back: req_valid held high, alternating SW then LW to same word
    accepts = 0; dones = 0; faults = 0; pend = 1'b0;
    @(negedge clk);
    sd_w = $urandom_range(0, 1023);
    req_op = 2'b10; req_opcode = 6'h2B; base = 32'(sd_w) * 4; offset = 16'd0;
    store_data = $urandom;
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (done) dones++;
      if (done && fault) faults++;
      if (pend) begin
        pend = 1'b0;
        if (req_op == 2'b10) begin
          req_op = 2'b01; req_opcode = 6'h23;
        end else begin
          sd_w = $urandom_range(0, 1023);
          req_op = 2'b10; req_opcode = 6'h2B; base = 32'(sd_w) * 4;
          store_data = $urandom;
        end
      end
      if (req_ready) begin
        accepts++;
        model_req(req_op, req_opcode, base, offset, store_data, tf, tl, ter, tew);
        pend = 1'b1;
      end else begin
        check_eq("tput.busy_when_not_ready", {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done) dones++;
      if (done && fault) faults++;
      @(negedge clk);
    end
    check_eq("tput.accepts", accepts, 5);
    check_eq("tput.dones", dones, accepts);
    check_eq("tput.faults", faults, 0);
    check_idle_outputs("tput_end");

    // Reset during ACCESS of a store
    @(negedge clk);
    req_op = 2'b10; req_opcode = 6'h2B; base = 32'h200; offset = 16'd0;
    store_data = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_abort.memw_before", {31'd0, MemW}, 32'd1);
    rst = 1'b0;
    #1;
    model_lmd = 32'd0; model_addr = 32'd0; model_wdata = 32'd0; model_opcode = 6'd0;
    check_idle_outputs("rst_abort.in_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("rst_abort.no_done", dones, 0);
    check_idle_outputs("rst_abort.after");
    run_req("rst_abort.lw", 2'b01, 6'h23, 32'h200, 16'h0000, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
